sample_playback_fifo: RTL

Sample buffer directly upstream of the codec audio interface. It accepts 16-bit PCM samples from the synthesizer/sampler voice logic at an arbitrary rate and presents one sample on `DATA` per codec frame, advancing on each rising edge of the interface's `data_over` strobe. It absorbs rate mismatch between the voice engine and the DAC, and flags overflow and underrun.

---
 rtl/sample_playback_fifo.sv | 75 +++++++
 1 files changed

// File: rtl/sample_playback_fifo.sv
// sample_playback_fifo: sample FIFO feeding the codec DATA word, advanced once per data_over rising edge.
// Ports: Clk/Reset (async active-low); wr_en/wr_data producer side with full/empty/level status;
// INIT_FINISH/data_over from the audio interface; DATA registered sample; overflow/underrun one-cycle pulses.
// Build option SAMPLE_FIFO_HOLD_EN: on underrun DATA repeats the last sample instead of going silent.
module sample_playback_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  INIT_FINISH,
  input  logic                  data_over,
  output logic [WIDTH-1:0]      DATA,
  output logic                  overflow,
  output logic                  underrun
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SAMPLE_FIFO_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic data_over_q, data_over_d, overflow_q, overflow_d, underrun_q, underrun_d;
  logic wr_acc, consume, rd_ok;
  assign full = level_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign DATA = data_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;
  always_comb begin
    wr_acc = wr_en & ~full;
    consume = data_over & ~data_over_q & INIT_FINISH;
    rd_ok = consume & ~empty;
    data_over_d = data_over;
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_acc);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_ok);
    level_d = level_q + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(rd_ok);
    overflow_d = wr_en & full;
    underrun_d = consume & empty;
    // underrun: hold build repeats the last sample, default build goes silent
    data_d = !INIT_FINISH ? '0 : rd_ok ? mem[rd_ptr_q] : consume ? (HOLD ? data_q : '0) : data_q;
  end
  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      data_q <= '0;
      data_over_q <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      data_q <= data_d;
      data_over_q <= data_over_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end
endmodule
